tff_seq_ctrl: RTL
=================

# tff_seq_ctrl

Sequencer and arbiter for a shared WIDTH-bit synchronous up-counter built from T flip-flops. Two requesters compete for the counter. The winner gets a clear pass, then exactly `len` count cycles, then a one-cycle completion pulse. The block sits between requesting control logic and the TFF counter datapath, generating every T input so the counter is never driven by two owners.

## Interface
- `WIDTH`, default 4: counter width and width of each length input.
- `clk` input 1: clock; all state changes on the rising edge.
- `res` input 1: asynchronous active-low reset; takes effect immediately when low, with no clock needed.
- `req` input 2: request per requester. Bit i must stay high from assertion until `done` with `done_id`=i.
- `len0` input WIDTH: count length for requester 0; sampled only on its grant.
- `len1` input WIDTH: count length for requester 1; sampled only on its grant.
- `gnt` output 2: one-hot ownership, or 0 when idle.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: single-cycle completion pulse.
- `done_id` output 1: index of the requester that completed; valid while `done`=1.
- `cnt` output WIDTH: counter value, taken directly from the TFF Q outputs.

## Operation
- The counter is WIDTH TFF cells, each holding Q and updating as Q ^ T. There is no load or synchronous clear; the FSM drives all T inputs.
- The FSM has four states: IDLE, CLEAR, RUN, DONE.
- **IDLE:** all T = 0, so `cnt` holds. If any `req` bit is high, the arbiter picks a winner and moves to CLEAR. On entry to CLEAR, `gnt` is set, the winner's `len` is captured in `len_q`, and `busy` = 1.
- **Arbitration:** round-robin. The `last` register records the most recently served requester. On a tie, the requester not equal to `last` wins.
- **CLEAR:** T[i] = Q[i], so `cnt` becomes 0 in one edge.
  - If `len_q` = 0, go to DONE.
  - Otherwise go to RUN.
- **RUN:** T[0] = 1 and T[i] = AND(Q[i-1:0]), which is binary increment.
  - When the edge makes `cnt` = `len_q`, go to DONE.
  - `cnt` never wraps, because `len_q` ≤ 2^WIDTH−1.
- **DONE:** all T = 0. `done` = 1, `done_id` = owner, `last` ← owner. Go to IDLE with `gnt` cleared.
- **Abort:** if the owner's `req` bit is low during CLEAR or RUN, go to IDLE on the next edge.
  - `gnt` is cleared and `cnt` holds its partial value.
  - No `done` pulse; `last` is not updated.
- **Non-owner requests:** a request from the non-owner during CLEAR, RUN, or DONE is ignored until IDLE. It is never dropped; it is served at the next arbitration if still high.
- **Reset values:** state IDLE, `gnt` = 0, `busy` = 0, `done` = 0, `done_id` = 0, `cnt` = 0, `len_q` = 0, `last` = 1 (requester 0 wins the first tie).
- **Reset mid-operation:** everything returns to the reset values at once. The counter zeroes asynchronously through the TFF resets.

## Timing
- Request high before edge E0 while in IDLE:
  - `gnt`/`busy` high after E0 (CLEAR).
  - `cnt` = 0 after E1.
  - `cnt` = 1 … `len_q` after E2 … E(len_q+1).
  - `done` high for the cycle after E(len_q+2); `gnt` low after E(len_q+3).
- Total ownership is `len_q` + 3 cycles. For `len_q` = 0, ownership is 2 cycles (CLEAR, DONE).
- **Back-to-back:** a pending other request is granted at the first edge after returning to IDLE, so there is one IDLE cycle between owners.
- The owner's `req` is checked on every edge during CLEAR and RUN. The abort takes effect on the edge at which `req` is seen low.
- `done` and `gnt` are registered outputs with no combinational path from `req`. `cnt` is purely registered.

## Configuration
- `TFF_SEQ_FIXED_PRIO_EN`
  - **Defined:** requester 0 always wins a tie. `last` is still updated but ignored.
  - **Undefined (default):** round-robin as described under Operation.

## Test plan
- **Reset then single request:** `res` low 10 ns then high, `req` = 01, `len0` = 3. Expect:
  - `gnt` = 01 for 6 cycles.
  - `cnt` sequence 0,1,2,3.
  - `done` pulse with `done_id` = 0.
  - `cnt` holds 3 afterwards.
- **Round-robin tie:** `req` = 11 held, `len0` = 2, `len1` = 1. Expect grants in the order 0, 1, 0, 1. Each `done_id` matches its grant, with one IDLE cycle between owners.
- **Zero length:** `req` = 10, `len1` = 0. Expect `gnt` = 10 for 2 cycles, `cnt` = 0, `done` with `done_id` = 1.
- **Abort:** `req` = 01, `len0` = 15, drop `req[0]` when `cnt` = 5. Expect IDLE on the next edge, `cnt` = 5 or 6 (value at that edge) held, no `done`, and `busy` = 0.
- **Reset mid-RUN:** pull `res` low when `cnt` = 4. Expect `cnt`, `gnt`, `busy`, and `done` all 0 immediately, without waiting for a clock edge.
- **Max length, `WIDTH` = 4:** `len0` = 15. Expect `cnt` to reach 15 with no wrap to 0, then `done`. With `TFF_SEQ_FIXED_PRIO_EN` defined and `req` = 11 held, requester 0 is granted repeatedly.

Source files
------------

// File: rtl/tff_seq_ctrl.sv
// Round-robin sequencer/arbiter driving the T inputs of a shared WIDTH-bit TFF up-counter.
// Define TFF_SEQ_FIXED_PRIO_EN to make requester 0 win every tie instead of alternating.
module tff_seq_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             res,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] len0,
   input  logic [WIDTH-1:0] len1,
   output logic [1:0]       gnt,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic [WIDTH-1:0] cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_len_q;
   logic [1:0]       r_gnt;
   logic             r_busy;
   logic             r_done;
   logic             r_done_id;
   logic             r_owner;
   logic             r_last;

   logic [WIDTH-1:0] w_t;
   logic             w_carry;
   logic             w_winner;
   logic             w_owner_req;

   assign gnt     = r_gnt;
   assign busy    = r_busy;
   assign done    = r_done;
   assign done_id = r_done_id;
   assign cnt     = r_q;

   assign w_owner_req = req[r_owner];

   // T inputs: CLEAR toggles every set bit to zero, RUN ripples an increment until len_q is reached
   always_comb begin
      w_t     = {WIDTH{1'b0}};
      w_carry = 1'b1;
      case (r_state)
         S_CLEAR: begin
            w_t = r_q;
         end
         S_RUN: begin
            if (r_q != r_len_q) begin
               for (int i = 0; i < WIDTH; i++) begin
                  w_t[i]  = w_carry;
                  w_carry = w_carry & r_q[i];
               end
            end else begin
               w_t = {WIDTH{1'b0}};
            end
         end
         default: begin
            w_t = {WIDTH{1'b0}};
         end
      endcase
   end

   // Tie-break between simultaneous requesters
   always_comb begin
      w_winner = 1'b0;
      case (req)
         2'b01:   w_winner = 1'b0;
         2'b10:   w_winner = 1'b1;
`ifdef TFF_SEQ_FIXED_PRIO_EN
         2'b11:   w_winner = 1'b0;
`else
         2'b11:   w_winner = ~r_last;
`endif
         default: w_winner = 1'b0;
      endcase
   end

   // TFF counter cells: each bit flips when its T input is high
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_q <= {WIDTH{1'b0}};
      end else begin
         r_q <= r_q ^ w_t;
      end
   end

   // Sequencer FSM with registered grant, busy and completion outputs
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_state   <= S_IDLE;
         r_gnt     <= 2'b00;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_done_id <= 1'b0;
         r_len_q   <= {WIDTH{1'b0}};
         r_owner   <= 1'b0;
         r_last    <= 1'b1;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (|req) begin
                  r_state <= S_CLEAR;
                  r_owner <= w_winner;
                  r_gnt   <= w_winner ? 2'b10 : 2'b01;
                  r_len_q <= w_winner ? len1 : len0;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_CLEAR: begin
               if (!w_owner_req) begin
                  r_state <= S_IDLE;
                  r_gnt   <= 2'b00;
                  r_busy  <= 1'b0;
               end else if (r_len_q == {WIDTH{1'b0}}) begin
                  r_state   <= S_DONE;
                  r_done    <= 1'b1;
                  r_done_id <= r_owner;
                  r_last    <= r_owner;
               end else begin
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (!w_owner_req) begin
                  r_state <= S_IDLE;
                  r_gnt   <= 2'b00;
                  r_busy  <= 1'b0;
               end else if (r_q == r_len_q) begin
                  r_state   <= S_DONE;
                  r_done    <= 1'b1;
                  r_done_id <= r_owner;
                  r_last    <= r_owner;
               end else begin
                  r_state <= S_RUN;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_gnt   <= 2'b00;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_gnt   <= 2'b00;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
